// File: rtl/kpb_pkg.sv
// rtl/kpb_pkg.sv - shared state type, constants and width helper for kp_buffer_sched (KPB_TIMEOUT_EN adds FLUSH)
package kpb_pkg;

  localparam int DROP_W = 8;

`ifdef KPB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} kpb_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} kpb_state_t;
`endif

  // Occupancy must be able to hold the value DEPTH itself, not just DEPTH-1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kpb_sat_cnt.sv
// rtl/kpb_sat_cnt.sv - saturating up-counter with synchronous clear
module kpb_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/kp_buffer_sched.sv
// rtl/kp_buffer_sched.sv - keypoint buffer frame scheduler (optional drain timeout via KPB_TIMEOUT_EN)
module kp_buffer_sched
  import kpb_pkg::*;
#(
  parameter int DEPTH       = 10,
  parameter int TIMEOUT_CYC = 1024,
  localparam int OCC_W      = occ_width(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_frame_end,
  input  logic              i_kp_valid,
  output logic              o_kp_ready,
  output logic              o_buf_valid,
  output logic              o_buf_next,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic [OCC_W-1:0]  o_occ,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic              o_done,
  output logic              o_overrun,
  output logic              o_timeout
);

  if (DEPTH < 2 || DEPTH > 255 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("kp_buffer_sched: DEPTH must be 2..255 and TIMEOUT_CYC at least 1");
  end

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DRAIN   = DRAIN;
`ifdef KPB_TIMEOUT_EN
  localparam logic [1:0] ST_FLUSH   = FLUSH;
`endif

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic [1:0]       state;
  logic [OCC_W-1:0] occ;
  logic             done_q;
  logic             overrun_q;
  logic             in_idle;
  logic             in_collect;
  logic             in_drain;
  logic             accept;
  logic             drop;
  logic             handshake;
  logic             flush_shift;

  assign in_idle    = (state == ST_IDLE);
  assign in_collect = (state == ST_COLLECT);
  assign in_drain   = (state == ST_DRAIN);

  // A keypoint is written only while a slot is free; the rest are counted as drops.
  assign accept    = in_collect && i_kp_valid && (occ != OCC_FULL);
  assign drop      = in_collect && i_kp_valid && (occ == OCC_FULL);
  assign handshake = o_out_valid && i_out_ready;

  assign o_kp_ready  = in_collect;
  assign o_buf_valid = accept;
  assign o_out_valid = in_drain && (occ != '0);
  assign o_out_last  = in_drain && (occ == OCC_ONE);
  assign o_buf_next  = handshake || flush_shift;
  assign o_occ       = occ;
  assign o_done      = done_q;
  assign o_overrun   = overrun_q;

  kpb_sat_cnt #(.W(DROP_W)) u_drop_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (in_idle && i_frame_start),
    .inc   (drop),
    .count (o_drop_cnt)
  );

`ifdef KPB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] stall_cnt;
  logic            stall;
  logic            timeout_fire;
  logic            timeout_q;

  // Stall cycles are counted only while the head is offered and refused.
  assign stall        = o_out_valid && !i_out_ready;
  assign timeout_fire = stall && (stall_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign flush_shift  = (state == ST_FLUSH) && (occ != '0);
  assign o_timeout    = timeout_q;

  kpb_sat_cnt #(.W(TO_W)) u_stall_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (!in_drain || handshake),
    .inc   (stall),
    .count (stall_cnt)
  );

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else if (timeout_fire) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign flush_shift = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Frame sequencing, occupancy tracking, done pulse and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      occ       <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_frame_start && !in_idle) begin
        overrun_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_frame_start) begin
            state <= ST_COLLECT;
            occ   <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            occ <= occ + 1'b1;
          end
          // A keypoint on the same cycle as frame end is counted before deciding.
          if (i_frame_end) begin
            if (accept || (occ != '0)) begin
              state <= ST_DRAIN;
            end else begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (handshake) begin
            occ <= occ - 1'b1;
            if (o_out_last) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
`ifdef KPB_TIMEOUT_EN
          else if (timeout_fire) begin
            state <= ST_FLUSH;
          end
`endif
        end
`ifdef KPB_TIMEOUT_EN
        ST_FLUSH: begin
          if (occ != '0) begin
            occ <= occ - 1'b1;
          end
          if (occ <= OCC_ONE) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
